pcler8_count_reg: RTL and testbench

- Sequential state-holding stage for the 8-bit parallel-load counter next-state logic.
- Registers the count, generates the cascade carry for the next 8-bit slice, supports a programmable reload value, and adds a one-shot/free-run control FSM.
- Its q output feeds the combinational next-state logic, and that logic's next-state result returns here as the registered count.
- Slices cascade through cin/cout to build 16/24/32-bit counters.

---
 rtl/pcler8_count_reg.sv | 102 ++++++++++
 tb/tb_pcler8_count_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pcler8_count_reg.sv
// Cascadable counter slice: registered count with programmable reload,
// terminal-count pulse, sticky overflow and a one-shot/free-run control FSM.
module pcler8_count_reg #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RELOAD_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             cin,
    input  logic             arm,
    input  logic             oneshot,
    input  logic             rl_wr,
    input  logic [WIDTH-1:0] rl_din,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             tc,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic             count_c;
    logic             tce_c;

    // Counting is suppressed by clr/load so a cascade never ripples on those cycles
    assign count_c = (state == RUN) && en && cin && !clr && !load;
    assign tce_c   = count_c && (q == ALL_ONES);
    assign cout    = tce_c;
    assign busy    = (state == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (arm) state_next = RUN;
                RUN:     if (tce_c && oneshot) state_next = DONE;
                DONE:    if (arm) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Count, terminal-count pulse and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= tce_c;
            if (tce_c) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (clr) begin
                q <= '0;
            end else if (load) begin
                q <= din;
            end else if (count_c) begin
                q <= tce_c ? reload : q + WIDTH'(1);
            end
        end
    end

    // Reload register; a same-cycle TCE still sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= RELOAD_RST;
        end else if (rl_wr) begin
            reload <= rl_din;
        end
    end

endmodule

// File: tb/tb_pcler8_count_reg.sv
// Directed self-checking bench for pcler8_count_reg, including a two-slice cascade.
module tb_pcler8_count_reg;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, cin, arm, oneshot, rl_wr, ovf_clr;
    logic [7:0] din, rl_din;
    logic [7:0] q;
    logic       cout, tc, ovf, busy;

    logic       hi_clr, hi_arm;
    logic [7:0] hi_q;
    logic       hi_cout, hi_tc, hi_ovf, hi_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcler8_count_reg #(.WIDTH(8), .RELOAD_RST(8'h00)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en),
        .cin(cin), .arm(arm), .oneshot(oneshot), .rl_wr(rl_wr), .rl_din(rl_din),
        .ovf_clr(ovf_clr), .q(q), .cout(cout), .tc(tc), .ovf(ovf), .busy(busy)
    );

    // Upper slice fed by the lower slice's carry
    pcler8_count_reg #(.WIDTH(8), .RELOAD_RST(8'h00)) u_hi (
        .clk(clk), .rst(rst), .clr(hi_clr), .load(1'b0), .din(8'h00), .en(1'b1),
        .cin(cout), .arm(hi_arm), .oneshot(1'b0), .rl_wr(1'b0), .rl_din(8'h00),
        .ovf_clr(1'b0), .q(hi_q), .cout(hi_cout), .tc(hi_tc), .ovf(hi_ovf), .busy(hi_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_q;
        rst = 1'b1; clr = 1'b0; load = 1'b1; din = 8'hAA; en = 1'b1; cin = 1'b1;
        arm = 1'b1; oneshot = 1'b0; rl_wr = 1'b0; rl_din = 8'h00; ovf_clr = 1'b0;
        hi_clr = 1'b0; hi_arm = 1'b0;

        // Reset overrides load/arm/en
        tick();
        check("rst_q", q, 8'h00);
        check("rst_tc", {7'd0, tc}, 8'h00);
        check("rst_ovf", {7'd0, ovf}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);

        // Free-run: arm one cycle, then 300 counting cycles
        rst = 1'b0; load = 1'b0; en = 1'b0; arm = 1'b1; hi_arm = 1'b1;
        tick();
        check("arm_busy", {7'd0, busy}, 8'h01);
        check("arm_nocount", q, 8'h00);
        arm = 1'b0; hi_arm = 1'b0; en = 1'b1;
        exp_q = 8'h00;
        for (int i = 0; i < 300; i++) begin
            check("run_cout", {7'd0, cout}, {7'd0, (i == 255)});
            tick();
            exp_q = exp_q + 8'd1;
            check("run_q", q, exp_q);
            check("run_tc", {7'd0, tc}, {7'd0, (i == 255)});
            check("run_ovf", {7'd0, ovf}, {7'd0, (i >= 255)});
            check("cascade_hi_q", hi_q, (i >= 255) ? 8'h01 : 8'h00);
        end

        // One-shot with reload F0 from a loaded FD
        en = 1'b0; clr = 1'b1;
        tick();
        check("clr_q", q, 8'h00);
        check("clr_idle", {7'd0, busy}, 8'h00);
        clr = 1'b0; rl_wr = 1'b1; rl_din = 8'hF0; load = 1'b1; din = 8'hFD;
        tick();
        check("os_load", q, 8'hFD);
        rl_wr = 1'b0; load = 1'b0; arm = 1'b1;
        tick();
        check("os_arm_hold", q, 8'hFD);
        arm = 1'b0; en = 1'b1; oneshot = 1'b1;
        tick();
        check("os_fe", q, 8'hFE);
        tick();
        check("os_ff", q, 8'hFF);
        tick();
        check("os_reload", q, 8'hF0);
        check("os_tc", {7'd0, tc}, 8'h01);
        check("os_done_busy", {7'd0, busy}, 8'h00);
        tick();
        check("os_done_hold", q, 8'hF0);
        check("os_tc_once", {7'd0, tc}, 8'h00);
        arm = 1'b1;
        tick();
        check("os_rearm_hold", q, 8'hF0);
        check("os_rearm_busy", {7'd0, busy}, 8'h01);
        arm = 1'b0;
        tick();
        check("os_resume", q, 8'hF1);

        // clr beats load; load beats count
        oneshot = 1'b0; en = 1'b0; load = 1'b1; din = 8'h42;
        tick();
        check("ld42", q, 8'h42);
        clr = 1'b1; din = 8'h77;
        tick();
        check("clr_over_load", q, 8'h00);
        check("clr_over_load_idle", {7'd0, busy}, 8'h00);
        clr = 1'b0; load = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0; en = 1'b1; load = 1'b1; din = 8'h99;
        #1;
        check("load_cout0", {7'd0, cout}, 8'h00);
        tick();
        check("load_over_count", q, 8'h99);
        load = 1'b0;
        tick();
        check("count_after_load", q, 8'h9A);

        // cin=0 blocks count and carry at all-ones
        en = 1'b0; load = 1'b1; din = 8'hFF;
        tick();
        load = 1'b0; en = 1'b1; cin = 1'b0;
        #1;
        check("cin0_cout", {7'd0, cout}, 8'h00);
        tick();
        check("cin0_hold", q, 8'hFF);
        cin = 1'b1;

        // TCE + ovf_clr + rl_wr in the same cycle
        en = 1'b0; rl_wr = 1'b1; rl_din = 8'h05; ovf_clr = 1'b1;
        tick();
        check("ovf_cleared", {7'd0, ovf}, 8'h00);
        en = 1'b1; rl_din = 8'h10;
        tick();
        check("sim_q_old_reload", q, 8'h05);
        check("sim_ovf_set_wins", {7'd0, ovf}, 8'h01);
        check("sim_tc", {7'd0, tc}, 8'h01);
        rl_wr = 1'b0; ovf_clr = 1'b0; load = 1'b1; din = 8'hFF;
        tick();
        load = 1'b0;
        tick();
        check("next_reload_new", q, 8'h10);

        // Reset mid-run restores reload to RELOAD_RST
        en = 1'b0; rl_wr = 1'b1; rl_din = 8'h33; load = 1'b1; din = 8'h79;
        tick();
        rl_wr = 1'b0; load = 1'b0; en = 1'b1;
        tick();
        check("pre_rst_q", q, 8'h7A);
        rst = 1'b1;
        tick();
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_tc", {7'd0, tc}, 8'h00);
        check("mid_rst_ovf", {7'd0, ovf}, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0; en = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0; load = 1'b1; din = 8'hFF;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        check("post_rst_reload", q, 8'h00);
        check("post_rst_tc", {7'd0, tc}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
